// File: rtl/dac_wavegen_pkg.sv
// Shared definitions for the multi-channel DAC waveform generator.
//  - Waveform mode encoding (2-bit) and its width.
//  - Per-channel reset defaults, which reproduce the legacy free-running up-ramp.
//  - Helper that sizes the channel-select field so a single channel still gets a 1-bit port.
package dac_wavegen_pkg;

   localparam int unsigned MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD     = 2'd0,
      MODE_SAW_UP   = 2'd1,
      MODE_SAW_DOWN = 2'd2,
      MODE_TRI      = 2'd3
   } mode_e;

   localparam mode_e       RST_MODE = MODE_SAW_UP;
   localparam int unsigned RST_STEP = 1;

   function automatic int unsigned ch_idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dac_wave_channel.sv
// One DAC channel: holds mode/step/start/direction and the output sample, and produces a
// one-clock write strobe in the cycle after each sample update.
// Ports:
//  clk        system clock
//  sReset_n   synchronous active-low reset
//  tick       prescaler update event
//  sync       restart at the stored start value (wins over tick)
//  apply      load a new configuration (wins over sync and tick)
//  cfg_mode   mode to load on apply
//  cfg_step   step to load on apply
//  cfg_start  start value to load on apply; also becomes the sample immediately
//  q          current DAC sample
//  strobe     DAC write strobe, one clock after q changes
module dac_wave_channel
   import dac_wavegen_pkg::*;
#(
   parameter int unsigned BITS = 8
) (
   input  logic            clk,
   input  logic            sReset_n,
   input  logic            tick,
   input  logic            sync,
   input  logic            apply,
   input  mode_e           cfg_mode,
   input  logic [BITS-1:0] cfg_step,
   input  logic [BITS-1:0] cfg_start,
   output logic [BITS-1:0] q,
   output logic            strobe
);

   localparam logic [BITS-1:0] MAX_V = {BITS{1'b1}};
   localparam logic [BITS:0]   MAX_W = {1'b0, MAX_V};

   mode_e           mode_q;
   logic [BITS-1:0] step_q;
   logic [BITS-1:0] start_q;
   logic [BITS-1:0] q_q;
   logic            dir_up_q;
   logic            evt_q;     // sample changed this cycle; strobe follows one clock later
   logic            strobe_q;

   logic [BITS:0]   sum_w;
   logic [BITS-1:0] q_next;
   logic            dir_up_next;

   // Next sample for a plain tick. The triangle uses the widened sum so it clamps at MAX
   // instead of wrapping.
   always_comb begin
      sum_w       = {1'b0, q_q} + {1'b0, step_q};
      q_next      = q_q;
      dir_up_next = dir_up_q;
      unique case (mode_q)
         MODE_HOLD:     q_next = q_q;
         MODE_SAW_UP:   q_next = sum_w[BITS-1:0];
         MODE_SAW_DOWN: q_next = q_q - step_q;
         MODE_TRI: begin
            if (dir_up_q) begin
               if (sum_w >= MAX_W) begin
                  q_next      = MAX_V;
                  dir_up_next = 1'b0;
               end else begin
                  q_next = sum_w[BITS-1:0];
               end
            end else begin
               if (q_q <= step_q) begin
                  q_next      = '0;
                  dir_up_next = 1'b1;
               end else begin
                  q_next = q_q - step_q;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sReset_n) begin
         mode_q   <= RST_MODE;
         step_q   <= BITS'(RST_STEP);
         start_q  <= '0;
         q_q      <= '0;
         dir_up_q <= 1'b1;
         evt_q    <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= evt_q;
         if (apply) begin
            mode_q   <= cfg_mode;
            step_q   <= cfg_step;
            start_q  <= cfg_start;
            q_q      <= cfg_start;
            dir_up_q <= 1'b1;
            evt_q    <= 1'b1;
         end else if (sync) begin
            q_q      <= start_q;
            dir_up_q <= 1'b1;
            evt_q    <= 1'b1;
         end else if (tick) begin
            q_q      <= q_next;
            dir_up_q <= dir_up_next;
            // A held channel has nothing new for the DAC, so it stays quiet on ticks.
            evt_q    <= (mode_q != MODE_HOLD);
         end else begin
            evt_q <= 1'b0;
         end
      end
   end

   assign q      = q_q;
   assign strobe = strobe_q;

endmodule

// File: rtl/dac_wavegen.sv
// Multi-channel DAC waveform generator. A shared prescaler produces update ticks; a single
// pending slot takes configuration requests and applies them on the next tick or sync.
// Out of reset every channel free-runs as a step-1 up-ramp, one update per clock.
// Ports:
//  clk        system clock
//  sReset_n   synchronous active-low reset
//  enable     prescaler run enable (frozen, no ticks, when low)
//  rate_div   tick period minus one, in clocks
//  sync       restart all channels at their start values
//  cfg_valid  configuration request
//  cfg_ready  pending slot free
//  cfg_ch     target channel; out-of-range values are accepted and dropped
//  cfg_mode   0 HOLD, 1 SAW_UP, 2 SAW_DOWN, 3 TRIANGLE
//  cfg_step   per-update increment
//  cfg_start  start value loaded on apply
//  dac_d      packed DAC data, channel n at [n*BITS +: BITS]
//  dac_c      per-channel DAC write strobes
module dac_wavegen
   import dac_wavegen_pkg::*;
#(
   parameter  int unsigned BITS  = 8,
   parameter  int unsigned CH    = 2,
   parameter  int unsigned DIV_W = 16,
   localparam int unsigned CH_W  = ch_idx_width(CH)
) (
   input  logic                clk,
   input  logic                sReset_n,
   input  logic                enable,
   input  logic [DIV_W-1:0]    rate_div,
   input  logic                sync,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [MODE_W-1:0]   cfg_mode,
   input  logic [BITS-1:0]     cfg_step,
   input  logic [BITS-1:0]     cfg_start,
   output logic [CH*BITS-1:0]  dac_d,
   output logic [CH-1:0]       dac_c
);

   // ---------------------------------------------------------------- prescaler
   logic [DIV_W-1:0] cnt_q;
   logic             tick;

   // ">=" rather than "==" so lowering rate_div below the running count wraps at once.
   assign tick = enable && (cnt_q >= rate_div);

   always_ff @(posedge clk) begin
      if (!sReset_n) begin
         cnt_q <= '0;
      end else if (sync || tick) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + DIV_W'(1);
      end
   end

   // ---------------------------------------------------------------- config slot
   logic            pend_q;
   logic            pend_d;
   logic [CH_W-1:0] pend_ch_q;
   mode_e           pend_mode_q;
   logic [BITS-1:0] pend_step_q;
   logic [BITS-1:0] pend_start_q;
   logic            cfg_ready_q;
   logic            accept;
   logic            apply;

   assign accept = cfg_valid && cfg_ready_q;
   assign apply  = pend_q && (tick || sync);

   always_comb begin
      pend_d = pend_q;
      if (apply) begin
         pend_d = 1'b0;
      end
      if (accept) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!sReset_n) begin
         pend_q       <= 1'b0;
         cfg_ready_q  <= 1'b0;
         pend_ch_q    <= '0;
         pend_mode_q  <= RST_MODE;
         pend_step_q  <= '0;
         pend_start_q <= '0;
      end else begin
         pend_q      <= pend_d;
         cfg_ready_q <= ~pend_d;
         if (accept) begin
            pend_ch_q    <= cfg_ch;
            pend_mode_q  <= mode_e'(cfg_mode);
            pend_step_q  <= cfg_step;
            pend_start_q <= cfg_start;
         end
      end
   end

   assign cfg_ready = cfg_ready_q;

   // ---------------------------------------------------------------- channels
   // A pending entry whose channel index matches no instance simply expires on apply.
   for (genvar n = 0; n < CH; n++) begin : g_ch
      localparam logic [CH_W-1:0] IDX = CH_W'(n);
      logic ch_apply;

      assign ch_apply = apply && (pend_ch_q == IDX);

      dac_wave_channel #(
         .BITS (BITS)
      ) u_ch (
         .clk       (clk),
         .sReset_n  (sReset_n),
         .tick      (tick),
         .sync      (sync),
         .apply     (ch_apply),
         .cfg_mode  (pend_mode_q),
         .cfg_step  (pend_step_q),
         .cfg_start (pend_start_q),
         .q         (dac_d[n*BITS +: BITS]),
         .strobe    (dac_c[n])
      );
   end

endmodule

// File: tb/tb_dac_wavegen.sv
// Bench for dac_wavegen. Three channels are instantiated so that a 2-bit channel select can
// carry an out-of-range index (3) to exercise the discard path.
module tb_dac_wavegen;

   localparam int unsigned BITS  = 8;
   localparam int unsigned CH    = 3;
   localparam int unsigned DIV_W = 16;
   localparam int unsigned CH_W  = 2;
   localparam int          MAXV  = 255;

   logic                clk = 1'b0;
   logic                sReset_n = 1'b0;
   logic                enable = 1'b1;
   logic [DIV_W-1:0]    rate_div = '0;
   logic                sync = 1'b0;
   logic                cfg_valid = 1'b0;
   logic                cfg_ready;
   logic [CH_W-1:0]     cfg_ch = '0;
   logic [1:0]          cfg_mode = '0;
   logic [BITS-1:0]     cfg_step = '0;
   logic [BITS-1:0]     cfg_start = '0;
   logic [CH*BITS-1:0]  dac_d;
   logic [CH-1:0]       dac_c;

   always #5 clk = ~clk;

   dac_wavegen #(
      .BITS  (BITS),
      .CH    (CH),
      .DIV_W (DIV_W)
   ) dut (
      .clk       (clk),
      .sReset_n  (sReset_n),
      .enable    (enable),
      .rate_div  (rate_div),
      .sync      (sync),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_mode  (cfg_mode),
      .cfg_step  (cfg_step),
      .cfg_start (cfg_start),
      .dac_d     (dac_d),
      .dac_c     (dac_c)
   );

   int checks = 0;
   int failures = 0;

   // Reference model state, plain integers.
   int m_q[CH];
   int m_mode[CH];
   int m_step[CH];
   int m_start[CH];
   bit m_up[CH];
   bit m_ev[CH];
   bit m_stb[CH];
   int m_cnt;
   bit m_pend;
   bit m_rdy;
   int m_p_ch, m_p_mode, m_p_step, m_p_start;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int dq(input int n);
      return int'(dac_d[n*BITS +: BITS]);
   endfunction

   // One waveform update of channel n from the behavioural rules.
   task automatic advance(input int n);
      int q, s;
      q = m_q[n];
      s = m_step[n];
      case (m_mode[n])
         1: q = (q + s) % (MAXV + 1);
         2: q = (q + MAXV + 1 - s) % (MAXV + 1);
         3: begin
            if (m_up[n]) begin
               if (q + s >= MAXV) begin q = MAXV; m_up[n] = 1'b0; end
               else q = q + s;
            end else begin
               if (q <= s) begin q = 0; m_up[n] = 1'b1; end
               else q = q - s;
            end
         end
         default: ;
      endcase
      m_q[n] = q;
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      bit tk, ap, acc;
      tk  = enable && (m_cnt >= int'(rate_div));
      ap  = m_pend && (tk || sync);
      acc = cfg_valid && m_rdy;
      if (!sReset_n) begin
         for (int n = 0; n < CH; n++) begin
            m_q[n] = 0; m_mode[n] = 1; m_step[n] = 1; m_start[n] = 0;
            m_up[n] = 1'b1; m_ev[n] = 1'b0; m_stb[n] = 1'b0;
         end
         m_cnt = 0; m_pend = 1'b0; m_rdy = 1'b0;
      end else begin
         for (int n = 0; n < CH; n++) begin
            m_stb[n] = m_ev[n];
            if (ap && m_p_ch == n) begin
               m_mode[n] = m_p_mode; m_step[n] = m_p_step; m_start[n] = m_p_start;
               m_q[n] = m_p_start; m_up[n] = 1'b1; m_ev[n] = 1'b1;
            end else if (sync) begin
               m_q[n] = m_start[n]; m_up[n] = 1'b1; m_ev[n] = 1'b1;
            end else if (tk) begin
               advance(n);
               m_ev[n] = (m_mode[n] != 0);
            end else begin
               m_ev[n] = 1'b0;
            end
         end
         if (sync || tk) m_cnt = 0;
         else if (enable) m_cnt++;
         if (ap) m_pend = 1'b0;
         if (acc) begin
            m_pend = 1'b1;
            m_p_ch = int'(cfg_ch); m_p_mode = int'(cfg_mode);
            m_p_step = int'(cfg_step); m_p_start = int'(cfg_start);
         end
         m_rdy = !m_pend;
      end
   endtask

   // Clock edge, model update, then compare all outputs at the following falling edge.
   task automatic step_clk(input string tag);
      logic [CH*BITS-1:0] exp_d;
      logic [CH-1:0]      exp_c;
      @(posedge clk);
      model_step();
      @(negedge clk);
      for (int n = 0; n < CH; n++) begin
         exp_d[n*BITS +: BITS] = BITS'(m_q[n]);
         exp_c[n] = m_stb[n];
      end
      check({tag, "_dac_d"}, longint'(dac_d), longint'(exp_d));
      check({tag, "_dac_c"}, longint'(dac_c), longint'(exp_c));
      check({tag, "_cfg_ready"}, longint'(cfg_ready), longint'(m_rdy));
   endtask

   typedef struct {
      string name;
      int    ch;
      int    mode;
      int    step;
      int    start;
      int    k;     // updates after the apply edge
      int    exp;   // expected sample on ch after k updates
   } vec_t;

   vec_t vecs[8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;

      vecs[0] = '{"tri_ch1_peak_fall", 1, 3, 100, 0,   4, 155};
      vecs[1] = '{"sawdn_ch0_wrap",    0, 2, 3,   1,   2, 251};
      vecs[2] = '{"sawup_ch0_wrap",    0, 1, 200, 100, 1, 44};
      vecs[3] = '{"tri_step0",         1, 3, 0,   7,   5, 7};
      vecs[4] = '{"tri_step255",       0, 3, 255, 0,   2, 0};
      vecs[5] = '{"hold_ch1",          1, 0, 9,   42,  5, 42};
      vecs[6] = '{"tri_ch2_clamp",     2, 3, 2,   250, 3, 255};
      vecs[7] = '{"sawup_255_wrap",    0, 1, 1,   255, 1, 0};

      // Reset state and legacy up-ramp.
      @(negedge clk);
      sReset_n = 1'b0; rate_div = '0; enable = 1'b1;
      step_clk("rst");
      step_clk("rst");
      check("rst_dac_d_zero", longint'(dac_d), 0);
      check("rst_dac_c_zero", longint'(dac_c), 0);
      check("rst_cfg_ready_low", longint'(cfg_ready), 0);
      sReset_n = 1'b1;
      for (int i = 0; i < 3; i++) step_clk("ramp");
      check("ramp_ch0_3", dq(0), 3);
      check("ramp_ch1_3", dq(1), 3);
      check("ramp_strobes", longint'(dac_c), 7);
      check("ramp_ready", longint'(cfg_ready), 1);
      for (int i = 0; i < 253; i++) step_clk("ramp");
      check("ramp_wrap_to_0", dq(0), 0);

      // rate_div=3: one update every fourth clock.
      sReset_n = 1'b0; rate_div = 16'd3;
      step_clk("div_rst");
      sReset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
         step_clk("div3");
         if (dac_c[0]) pulses++;
      end
      check("div3_value", dq(0), 4);
      check("div3_pulses", pulses, 3);

      // Table-driven configurations at one update per clock.
      rate_div = '0;
      foreach (vecs[i]) begin
         cfg_valid = 1'b1;
         cfg_ch    = CH_W'(vecs[i].ch);
         cfg_mode  = 2'(vecs[i].mode);
         cfg_step  = BITS'(vecs[i].step);
         cfg_start = BITS'(vecs[i].start);
         step_clk(vecs[i].name);
         cfg_valid = 1'b0;
         check({vecs[i].name, "_ready_low"}, longint'(cfg_ready), 0);
         step_clk(vecs[i].name);
         for (int k = 0; k < vecs[i].k; k++) step_clk(vecs[i].name);
         check({vecs[i].name, "_value"}, dq(vecs[i].ch), vecs[i].exp);
      end

      // Sync coinciding with a tick, then prescaler restart.
      sReset_n = 1'b0;
      step_clk("sync_rst");
      sReset_n = 1'b1;
      for (int i = 0; i < 5; i++) step_clk("sync_pre");
      sync = 1'b1;
      step_clk("sync");
      sync = 1'b0; rate_div = 16'd2;
      check("sync_reload", longint'(dac_d), 0);
      step_clk("sync_post");
      step_clk("sync_post");
      check("sync_no_tick_yet", dq(0), 0);
      step_clk("sync_post");
      check("sync_first_tick", dq(0), 1);

      // Sync in the cycle after accept applies the pending entry.
      rate_div = 16'd100;
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_mode = 2'd1; cfg_step = 8'd5; cfg_start = 8'd77;
      step_clk("acc_sync");
      cfg_valid = 1'b0; sync = 1'b1;
      check("acc_sync_ready_low", longint'(cfg_ready), 0);
      step_clk("acc_sync");
      sync = 1'b0;
      check("acc_sync_applied", dq(2), 77);
      check("acc_sync_ch0_start", dq(0), 0);
      check("acc_sync_ready_back", longint'(cfg_ready), 1);

      // Out-of-range channel: accepted, dropped, ready recovers.
      rate_div = '0;
      cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_mode = 2'd0; cfg_step = 8'd0; cfg_start = 8'd99;
      step_clk("discard");
      cfg_valid = 1'b0;
      check("discard_ready_low", longint'(cfg_ready), 0);
      step_clk("discard");
      check("discard_ready_back", longint'(cfg_ready), 1);
      check("discard_ch2_untouched", dq(2), 87);

      // HOLD: one strobe for the apply, then silence.
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_mode = 2'd0; cfg_step = 8'd9; cfg_start = 8'd42;
      step_clk("hold");
      cfg_valid = 1'b0;
      step_clk("hold");
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         step_clk("hold");
         if (dac_c[0]) pulses++;
      end
      check("hold_value", dq(0), 42);
      check("hold_one_strobe", pulses, 1);

      // Reset mid-run drops a pending entry.
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_mode = 2'd3; cfg_step = 8'd50; cfg_start = 8'd200;
      step_clk("midrst");
      cfg_valid = 1'b0; sReset_n = 1'b0;
      step_clk("midrst");
      check("midrst_dac_d", longint'(dac_d), 0);
      check("midrst_dac_c", longint'(dac_c), 0);
      check("midrst_ready", longint'(cfg_ready), 0);
      sReset_n = 1'b1;
      step_clk("midrst_post");
      step_clk("midrst_post");
      check("midrst_pending_lost", dq(1), 2);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         sReset_n  = ($urandom_range(0, 399) != 0);
         enable    = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 49) == 0) rate_div = DIV_W'($urandom_range(0, 4));
         sync      = ($urandom_range(0, 39) == 0);
         cfg_valid = ($urandom_range(0, 5) == 0);
         cfg_ch    = CH_W'($urandom_range(0, 3));
         cfg_mode  = 2'($urandom_range(0, 3));
         cfg_step  = ($urandom_range(0, 1) != 0) ? BITS'($urandom_range(0, 255))
                                                 : BITS'($urandom_range(0, 4));
         cfg_start = BITS'($urandom_range(0, 255));
         step_clk("rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
